raggedstone_spinn_aer_if_7seg_decoder: RTL and testbench
========================================================

Name: raggedstone_spinn_aer_if_7seg_decoder

Overview:
Receive-side decoder for the multiplexed 7-segment display bus driven by the board user interface (segment byte plus one-hot digit strobe). Samples the bus and reconstructs the four digit codes and decimal points, then recovers the selected mode and virtual coordinate. Used on a monitor/companion FPGA and as a self-check against the user-interface output.

Parameters:
SETTLE_CYCLES, 4, consecutive stable clk cycles required before a digit is captured
TIMEOUT_BITS, 20, width of no-activity counter; link_lost asserts after 2^TIMEOUT_BITS-1 cycles with no strobe change

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
seg_in  in  8  segment byte, active-low: [7]=point, [6:0]=abcdefg
strobe_in  in  4  digit select, one-hot, active-high; bit n = digit n
digits  out  16  captured digit codes; digit n at [4n+3:4n]
points  out  4  captured points, active-low, bit n = digit n
frame_valid  out  1  one-cycle pulse when a complete frame is published
mode  out  3  decoded mode: " 128"=0, "  64"=1, "  32"=2, "  16"=3, "coch"=4, "0000"=5
vcoord  out  1  1 when points[0]==0, else 0
mode_valid  out  1  level; last published frame matched a known mode
decode_err  out  1  one-cycle pulse: unknown segment pattern or multi-hot strobe
link_lost  out  1  level; no strobe activity within timeout

Behaviour:
- Reset values: digits=16'hAAAA (all space), points=4'hF, frame_valid=0, mode=0, vcoord=0, mode_valid=0, decode_err=0, link_lost=0; FSM in WAIT; expected index=0; settle and timeout counters=0.
- Input sync: seg_in and strobe_in each pass through a 2-flop synchronizer; all logic below uses the synchronized values.
- Segment decode on [6:0]:
  - 01h=0, 4Fh=1, 12h=2, 06h=3, 4Ch=4, 24h=5, 60h=6, 0Fh=7, 00h=8, 0Ch=9, 7Fh=10 (space), 72h=11 (c), 62h=12 (o), 68h=13 (h).
  - Any other pattern decodes to 15 and flags an error.
- FSM states and transitions:
  - WAIT: on a valid one-hot strobe, latch the strobe and segments, clear settle count, go to SETTLE.
  - SETTLE: if strobe and segments equal the latched values, count up; otherwise re-latch and restart the count. When the count reaches SETTLE_CYCLES, capture and go to HOLD.
  - HOLD: stay until the strobe differs from the latched value, then go to WAIT.
  - Strobe 0000 in any state: go to WAIT, no error.
  - Multi-hot strobe in any state: go to WAIT and pulse decode_err.
- Capture of digit index i:
  - Write the decoded code into a shadow digit i and seg[7] into shadow point i.
  - Pattern 15: pulse decode_err and abort the frame (expected index=0).
  - i==expected: expected increments.
  - i!=expected: if i==0, restart the frame with expected=1; otherwise abort (expected=0).
- Frame publish:
  - Capture of index 3 while expected==3: in the next cycle copy shadows to digits/points, pulse frame_valid, update mode/vcoord/mode_valid; expected returns to 0.
  - Partial frames are never published.
- Mode match uses the full 16-bit digit word (digit0..3): {A,1,2,8}->0, {A,A,6,4}->1, {A,A,3,2}->2, {A,A,1,6}->3, {B,C,B,D}->4, {0,0,0,0}->5.
  - No match: mode_valid=0 and mode holds its previous value.
- link_lost:
  - Timeout counter resets on every change of the synchronized strobe and otherwise saturates.
  - link_lost=1 while the counter is saturated; it clears on the first strobe change.
  - Published outputs are retained while lost.
- Reset mid-frame: all state returns to reset values immediately; the partial frame is discarded.
- Latency: published outputs appear 2 (sync) + SETTLE_CYCLES + 2 cycles after the digit-3 bus value becomes stable.

Test Plan:
- Strobe 1,2,4,8 with seg FFh,CFh,92h,80h, each held 20 cycles -> one frame_valid pulse; digits=16'h821A, points=F, mode=0, vcoord=0, mode_valid=1.
- Same sequence but digit0 seg=7Fh -> points=4'hE, vcoord=1, mode=0.
- Cochlea seg F2h,E2h,F2h,E8h -> digits=16'hDBCB, mode=4; then 81h x4 -> mode=5.
- Digit1 seg=FEh (pattern 7Eh) -> decode_err pulse, no frame_valid for that pass; the next clean pass publishes normally.
- Strobe 0011 mid-frame -> decode_err pulse, frame aborted; strobe order 1,4,2,8 -> no frame_valid.
- Glitch: digit changes after 2 stable cycles -> settle restarts, no capture. Strobe held constant 2^20 cycles -> link_lost=1; a strobe change clears it. Assert rst mid-frame -> outputs return to reset values.

Source files
------------

// File: rtl/raggedstone_spinn_aer_if_7seg_decoder.sv
// Receive-side decoder for the multiplexed 7-segment display bus.
// Samples the segment byte and one-hot digit strobe, waits for each digit to
// settle, reassembles a four-digit frame in shadow registers and publishes it
// only when digits 0..3 arrive in order. The published word is then matched
// against the known display modes.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   seg_in       : segment byte, active-low, [7]=point, [6:0]=abcdefg
//   strobe_in    : one-hot digit select, bit n = digit n
//   digits       : published digit codes, digit n at [4n+3:4n]
//   points       : published points, active-low
//   frame_valid  : one-cycle pulse per published frame
//   mode, vcoord : decoded mode and virtual coordinate
//   mode_valid   : last published frame matched a known mode
//   decode_err   : pulse on unknown pattern or multi-hot strobe
//   link_lost    : no strobe change within the timeout
//
// state  | meaning
// WAIT   | idle, waiting for a valid one-hot strobe
// SETTLE | bus latched, counting consecutive stable cycles
// HOLD   | digit captured, waiting for the strobe to move on
module raggedstone_spinn_aer_if_7seg_decoder #(
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_BITS  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  strobe_in,
  output logic [15:0] digits,
  output logic [3:0]  points,
  output logic        frame_valid,
  output logic [2:0]  mode,
  output logic        vcoord,
  output logic        mode_valid,
  output logic        decode_err,
  output logic        link_lost
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {WAIT, SETTLE, HOLD} state_t;

  state_t                  state;
  logic [7:0]              seg_m, seg_s, seg_lat;
  logic [3:0]              strb_m, strb_s, strb_prev, strb_lat;
  logic [CW-1:0]           settle_cnt;
  logic [1:0]              exp_idx;
  logic [15:0]             sh_digits;
  logic [3:0]              sh_points;
  logic                    publish;
  logic [TIMEOUT_BITS-1:0] to_cnt;

  logic       strb_zero, strb_onehot, strb_multi, strb_chg, same;
  logic [3:0] lat_code;
  logic [1:0] lat_idx;
  logic       match_hit;
  logic [2:0] match_mode;

  function automatic logic [3:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h01:   return 4'd0;
      7'h4F:   return 4'd1;
      7'h12:   return 4'd2;
      7'h06:   return 4'd3;
      7'h4C:   return 4'd4;
      7'h24:   return 4'd5;
      7'h60:   return 4'd6;
      7'h0F:   return 4'd7;
      7'h00:   return 4'd8;
      7'h0C:   return 4'd9;
      7'h7F:   return 4'd10;
      7'h72:   return 4'd11;
      7'h62:   return 4'd12;
      7'h68:   return 4'd13;
      default: return 4'd15;
    endcase
  endfunction

  assign strb_zero   = (strb_s == 4'd0);
  assign strb_onehot = !strb_zero && ((strb_s & (strb_s - 4'd1)) == 4'd0);
  assign strb_multi  = !strb_zero && !strb_onehot;
  assign strb_chg    = (strb_s != strb_prev);
  assign same        = (strb_s == strb_lat) && (seg_s == seg_lat);
  assign lat_code    = seg_decode(seg_lat[6:0]);
  assign link_lost   = (to_cnt == '1);

  always_comb begin
    lat_idx = 2'd0;
    case (strb_lat)
      4'b0010: lat_idx = 2'd1;
      4'b0100: lat_idx = 2'd2;
      4'b1000: lat_idx = 2'd3;
      default: lat_idx = 2'd0;
    endcase
  end

  // Digit word is {digit3,digit2,digit1,digit0}
  always_comb begin
    match_hit  = 1'b1;
    match_mode = 3'd0;
    case (sh_digits)
      16'h821A: match_mode = 3'd0;
      16'h46AA: match_mode = 3'd1;
      16'h23AA: match_mode = 3'd2;
      16'h61AA: match_mode = 3'd3;
      16'hDBCB: match_mode = 3'd4;
      16'h0000: match_mode = 3'd5;
      default:  match_hit  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT;
      seg_m       <= 8'hFF;
      seg_s       <= 8'hFF;
      seg_lat     <= 8'hFF;
      strb_m      <= 4'd0;
      strb_s      <= 4'd0;
      strb_prev   <= 4'd0;
      strb_lat    <= 4'd0;
      settle_cnt  <= '0;
      exp_idx     <= 2'd0;
      sh_digits   <= 16'hAAAA;
      sh_points   <= 4'hF;
      publish     <= 1'b0;
      to_cnt      <= '0;
      digits      <= 16'hAAAA;
      points      <= 4'hF;
      frame_valid <= 1'b0;
      mode        <= 3'd0;
      vcoord      <= 1'b0;
      mode_valid  <= 1'b0;
      decode_err  <= 1'b0;
    end else begin
      seg_m     <= seg_in;
      seg_s     <= seg_m;
      strb_m    <= strobe_in;
      strb_s    <= strb_m;
      strb_prev <= strb_s;

      if (strb_chg)
        to_cnt <= '0;
      else if (to_cnt != '1)
        to_cnt <= to_cnt + 1'b1;

      frame_valid <= 1'b0;
      decode_err  <= 1'b0;
      publish     <= 1'b0;

      if (strb_zero) begin
        state <= WAIT;
      end else if (strb_multi) begin
        // Bus contention aborts the frame; flag only on entry so a held
        // multi-hot strobe yields a single pulse.
        state   <= WAIT;
        exp_idx <= 2'd0;
        if (strb_chg)
          decode_err <= 1'b1;
      end else begin
        case (state)
          WAIT: begin
            strb_lat   <= strb_s;
            seg_lat    <= seg_s;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
          SETTLE: begin
            if (!same) begin
              strb_lat   <= strb_s;
              seg_lat    <= seg_s;
              settle_cnt <= '0;
            end else if (settle_cnt == SETTLE_LAST) begin
              state <= HOLD;
              sh_digits[{lat_idx, 2'b00} +: 4] <= lat_code;
              sh_points[lat_idx]               <= seg_lat[7];
              if (lat_code == 4'd15) begin
                decode_err <= 1'b1;
                exp_idx    <= 2'd0;
              end else if (lat_idx == exp_idx) begin
                if (lat_idx == 2'd3) begin
                  publish <= 1'b1;
                  exp_idx <= 2'd0;
                end else begin
                  exp_idx <= exp_idx + 2'd1;
                end
              end else begin
                // A digit 0 out of sequence starts a fresh frame
                exp_idx <= (lat_idx == 2'd0) ? 2'd1 : 2'd0;
              end
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          HOLD: begin
            if (strb_s != strb_lat)
              state <= WAIT;
          end
          default: state <= WAIT;
        endcase
      end

      if (publish) begin
        digits      <= sh_digits;
        points      <= sh_points;
        frame_valid <= 1'b1;
        vcoord      <= ~sh_points[0];
        mode_valid  <= match_hit;
        if (match_hit)
          mode <= match_mode;
      end
    end
  end

endmodule

// File: tb/tb_raggedstone_spinn_aer_if_7seg_decoder.sv
// Self-checking bench for the 7-segment bus decoder: directed cases plus
// randomized frames compared against a frame-level reference model.
module tb_raggedstone_spinn_aer_if_7seg_decoder;

  localparam int SETTLE  = 4;
  localparam int TO_BITS = 10;
  localparam int HOLD_CY = 20;

  localparam logic [6:0] SEG_TAB [14] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
    7'h24, 7'h60, 7'h0F, 7'h00, 7'h0C, 7'h7F, 7'h72, 7'h62, 7'h68};
  localparam logic [15:0] MODE_WORDS [6] = '{16'h821A, 16'h46AA, 16'h23AA,
    16'h61AA, 16'hDBCB, 16'h0000};
  localparam logic [6:0] BAD_TAB [3] = '{7'h7E, 7'h55, 7'h2A};

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_in;
  logic [3:0]  strobe_in;
  logic [15:0] digits;
  logic [3:0]  points;
  logic        frame_valid;
  logic [2:0]  mode;
  logic        vcoord;
  logic        mode_valid;
  logic        decode_err;
  logic        link_lost;

  raggedstone_spinn_aer_if_7seg_decoder #(
    .SETTLE_CYCLES(SETTLE),
    .TIMEOUT_BITS (TO_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .strobe_in  (strobe_in),
    .digits     (digits),
    .points     (points),
    .frame_valid(frame_valid),
    .mode       (mode),
    .vcoord     (vcoord),
    .mode_valid (mode_valid),
    .decode_err (decode_err),
    .link_lost  (link_lost)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fv_seen  = 0;
  int err_seen = 0;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_seen++;
    if (decode_err === 1'b1) err_seen++;
  end

  // Reference model state (frame level, one entry per held bus value)
  int          exp_m;
  logic [3:0]  sh_d [4];
  logic        sh_p [4];
  logic [3:0]  prev_strobe;
  logic [15:0] m_digits;
  logic [3:0]  m_points;
  int          m_mode;
  logic        m_mode_valid;
  logic        m_vcoord;
  int          m_frames = 0;
  int          m_errs   = 0;

  function automatic int code_of(input logic [6:0] p);
    for (int i = 0; i < 14; i++)
      if (SEG_TAB[i] == p) return i;
    return 15;
  endfunction

  task automatic model_reset();
    exp_m        = 0;
    prev_strobe  = 4'd0;
    m_digits     = 16'hAAAA;
    m_points     = 4'hF;
    m_mode       = 0;
    m_mode_valid = 1'b0;
    m_vcoord     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sh_d[i] = 4'hA;
      sh_p[i] = 1'b1;
    end
  endtask

  task automatic model_publish();
    int k;
    m_digits = {sh_d[3], sh_d[2], sh_d[1], sh_d[0]};
    m_points = {sh_p[3], sh_p[2], sh_p[1], sh_p[0]};
    m_vcoord = ~sh_p[0];
    m_frames++;
    k = -1;
    for (int j = 0; j < 6; j++)
      if (MODE_WORDS[j] == m_digits) k = j;
    if (k >= 0) begin
      m_mode       = k;
      m_mode_valid = 1'b1;
    end else begin
      m_mode_valid = 1'b0;
    end
  endtask

  task automatic model_step(input logic [3:0] strobe, input logic [7:0] seg);
    int ones, idx, c;
    ones = $countones(strobe);
    if (ones > 1) begin
      if (strobe != prev_strobe) m_errs++;
      exp_m = 0;
    end else if (ones == 1 && strobe != prev_strobe) begin
      idx = 0;
      for (int b = 0; b < 4; b++)
        if (strobe[b]) idx = b;
      c = code_of(seg[6:0]);
      sh_d[idx] = 4'(c);
      sh_p[idx] = seg[7];
      if (c == 15) begin
        m_errs++;
        exp_m = 0;
      end else if (idx == exp_m) begin
        if (idx == 3) begin
          model_publish();
          exp_m = 0;
        end else begin
          exp_m++;
        end
      end else begin
        exp_m = (idx == 0) ? 1 : 0;
      end
    end
    prev_strobe = strobe;
  endtask

  task automatic step(input logic [3:0] strobe, input logic [7:0] seg, input int cycles);
    @(negedge clk);
    strobe_in = strobe;
    seg_in    = seg;
    repeat (cycles) @(negedge clk);
    model_step(strobe, seg);
  endtask

  // Random-order helper: a repeat of the same strobe needs a blank between
  task automatic rstep(input logic [3:0] strobe, input logic [7:0] seg);
    if (strobe != 4'd0 && strobe == prev_strobe) step(4'd0, 8'hFF, HOLD_CY);
    step(strobe, seg, HOLD_CY);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_digits"}, 32'(digits), 32'(m_digits));
    chk({tag, "_points"}, 32'(points), 32'(m_points));
    chk({tag, "_mode"}, 32'(mode), 32'(m_mode));
    chk({tag, "_mode_valid"}, 32'(mode_valid), 32'(m_mode_valid));
    chk({tag, "_vcoord"}, 32'(vcoord), 32'(m_vcoord));
    chk({tag, "_frames"}, 32'(fv_seen), 32'(m_frames));
    chk({tag, "_errs"}, 32'(err_seen), 32'(m_errs));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_digits"}, 32'(digits), 32'h0000AAAA);
    chk({tag, "_points"}, 32'(points), 32'hF);
    chk({tag, "_fv"}, 32'(frame_valid), 32'h0);
    chk({tag, "_mode"}, 32'(mode), 32'h0);
    chk({tag, "_vcoord"}, 32'(vcoord), 32'h0);
    chk({tag, "_mode_valid"}, 32'(mode_valid), 32'h0);
    chk({tag, "_err"}, 32'(decode_err), 32'h0);
    chk({tag, "_lost"}, 32'(link_lost), 32'h0);
  endtask

  task automatic send4(input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3);
    rstep(4'b0001, s0);
    rstep(4'b0010, s1);
    rstep(4'b0100, s2);
    rstep(4'b1000, s3);
  endtask

  function automatic logic [7:0] seg_for(input logic [3:0] code, input logic pt);
    return {pt, SEG_TAB[code]};
  endfunction

  initial begin
    logic [15:0] w;
    logic [7:0]  s [4];
    int          kind, bad;

    rst       = 1'b1;
    seg_in    = 8'hFF;
    strobe_in = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    send4(8'hFF, 8'hCF, 8'h92, 8'h80);
    chk("m128_digits_const", 32'(digits), 32'h821A);
    chk("m128_mode_const", 32'(mode), 32'h0);
    check_outputs("m128");

    send4(8'h7F, 8'hCF, 8'h92, 8'h80);
    chk("vc_points_const", 32'(points), 32'hE);
    chk("vc_vcoord_const", 32'(vcoord), 32'h1);
    check_outputs("vcoord");

    send4(8'hF2, 8'hE2, 8'hF2, 8'hE8);
    chk("coch_digits_const", 32'(digits), 32'hDBCB);
    chk("coch_mode_const", 32'(mode), 32'h4);
    check_outputs("cochlea");

    send4(8'h81, 8'h81, 8'h81, 8'h81);
    chk("zero_mode_const", 32'(mode), 32'h5);
    check_outputs("zeros");

    send4(8'hFF, 8'hFE, 8'h92, 8'h80);
    check_outputs("badseg");
    send4(8'hFF, 8'hCF, 8'h92, 8'h80);
    check_outputs("after_badseg");

    rstep(4'b0001, 8'hFF);
    rstep(4'b0010, 8'hCF);
    rstep(4'b0011, 8'hCF);
    rstep(4'b0100, 8'h92);
    rstep(4'b1000, 8'h80);
    check_outputs("multihot");

    rstep(4'b0001, 8'hF2);
    rstep(4'b0100, 8'hE2);
    rstep(4'b0010, 8'hF2);
    rstep(4'b1000, 8'hE8);
    check_outputs("order");

    // Short-lived digit 0 value must not be captured
    @(negedge clk);
    strobe_in = 4'b0001;
    seg_in    = 8'h92;
    repeat (3) @(negedge clk);
    step(4'b0001, 8'hFF, HOLD_CY);
    rstep(4'b0010, 8'hCF);
    rstep(4'b0100, 8'h92);
    rstep(4'b1000, 8'h80);
    chk("glitch_digits_const", 32'(digits), 32'h821A);
    check_outputs("glitch");

    for (int p = 0; p < 40; p++) begin
      kind = $urandom_range(0, 4);
      w = MODE_WORDS[$urandom_range(0, 5)];
      if (kind == 1)
        for (int d = 0; d < 4; d++) w[4*d +: 4] = 4'($urandom_range(0, 13));
      for (int d = 0; d < 4; d++)
        s[d] = seg_for(w[4*d +: 4], 1'($urandom_range(0, 1)));
      if (kind == 2) begin
        bad = $urandom_range(0, 2);
        s[$urandom_range(0, 3)][6:0] = BAD_TAB[bad];
      end
      if (kind == 3) begin
        for (int k = 0; k < 6; k++) begin
          int d;
          d = $urandom_range(0, 3);
          if ($urandom_range(0, 7) == 0) rstep(4'b0110, s[d]);
          else rstep(4'(1 << d), s[d]);
        end
      end else begin
        for (int d = 0; d < 4; d++) begin
          if (kind == 4) rstep(4'd0, 8'hFF);
          rstep(4'(1 << d), s[d]);
        end
      end
      check_outputs($sformatf("rand%0d", p));
    end

    step(4'b0001, 8'hFF, 900);
    chk("lost_early", 32'(link_lost), 32'h0);
    repeat (300) @(negedge clk);
    chk("lost_set", 32'(link_lost), 32'h1);
    chk("lost_retain_digits", 32'(digits), 32'(m_digits));
    step(4'b0010, 8'hCF, 5);
    chk("lost_clear", 32'(link_lost), 32'h0);
    repeat (HOLD_CY) @(negedge clk);
    rstep(4'b0100, 8'h92);
    rstep(4'b1000, 8'h80);
    check_outputs("lost_frame");

    rstep(4'b0001, 8'hF2);
    rstep(4'b0010, 8'hE2);
    rst       = 1'b1;
    strobe_in = 4'd0;
    repeat (2) @(negedge clk);
    check_reset("midreset");
    model_reset();
    rst = 1'b0;
    rstep(4'b0100, 8'hF2);
    rstep(4'b1000, 8'hE8);
    check_outputs("post_reset_partial");
    send4(8'hFF, 8'hFF, 8'hE0, 8'hCC);
    check_outputs("post_reset_full");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
